dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port, with a valid/ready request/response handshake and a programmable access latency.
- Replaces the zero-wait combinational data memory when the core is moved to a handshaked load/store interface.
- Holds a word-addressed RAM. Supports byte-strobed writes. Flags misaligned and out-of-range accesses with an error response.
- Handles one outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits
LATENCY, 2, wait cycles between request accept and response; legal range 0..15

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  responder can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte write enables; bit i enables wdata[8i+7:8i]
rsp_valid  out  1  response valid
rsp_ready  in  1  core can accept the response
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  access error

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - RAM contents are not reset and are retained across rst.
- Handshakes:
  - Request fires when req_valid & req_ready at an edge.
  - Response fires when rsp_valid & rsp_ready at an edge.
  - req_ready is high only in IDLE.
  - rsp_valid is high only in RESP.
  - Both outputs come directly from state flops. There are no combinational paths from inputs to outputs.
- On accept, register we, addr, wdata and wstrb.
- Error check is done on the registered address: err = addr[1:0]!=0 OR addr[31:ADDR_WIDTH+2]!=0.
- States:
  - IDLE: on request fire, go to WAIT with cnt=LATENCY-1. If LATENCY=0, go directly to RESP, performing the access on that same edge.
  - WAIT: if cnt==0, perform the access and go to RESP; otherwise decrement cnt.
  - RESP: hold rsp_valid, rsp_rdata and rsp_err stable until the response fires, then go to IDLE.
- Access:
  - Read: rsp_rdata=RAM[addr[ADDR_WIDTH+1:2]], rsp_err=0.
  - Write: each byte with its strobe bit set is updated, rsp_rdata=0, rsp_err=0.
  - Write with wstrb=0: no RAM change, normal response.
  - Error: RAM untouched, rsp_rdata=0, rsp_err=1.
- Latency: accept at edge E makes rsp_valid high from edge E+LATENCY+1. Earliest next accept is at edge E+LATENCY+2, when rsp_ready is held high.
- rsp_ready may already be high when rsp_valid rises. The response then fires at the next edge and req_ready is high in the following cycle.
- rsp_ready low: stay in RESP indefinitely with outputs stable. req_valid is ignored while busy.
- Ordering: a read following a write to the same word returns the post-write data.
- Reset mid-operation: the transaction is abandoned. A write still in WAIT is not committed. A write already committed (in RESP) stays in RAM.
- rst and request fire at the same edge: rst wins, the request is dropped, and req_ready=1 next cycle.
- Address wrap: none. Out-of-range addresses error rather than alias.

Test Plan:
1. Reset, then LATENCY=2. Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10. Write response has rsp_valid high 3 cycles after accept, rdata=0, err=0. Read returns 0xDEADBEEF, err=0.
2. Byte strobes: preload 0x11223344 at 0x20. Write wdata 0xAABBCCDD with wstrb 0b0101. Read 0x20 returns 0x11BB33DD.
3. Errors: read 0x21, then write 0x00001000 with ADDR_WIDTH=10 and wdata 0xFFFFFFFF. Both give rsp_err=1 and rdata=0. A read of 0x000 afterwards shows it unchanged.
4. Backpressure: hold rsp_ready=0 for 5 cycles on a read of 0x10. rsp_valid, rdata and err stay stable. req_ready stays 0 while req_valid=1. Release, and the response fires once; req_ready=1 next cycle.
5. LATENCY=0 back-to-back, with rsp_ready tied high: accepts occur every 2 cycles. Each rsp_valid appears 1 cycle after its accept with correct data.
6. Reset in WAIT: LATENCY=4, write 0x55AA55AA to 0x30 (old value 0x0), assert rst 2 cycles after accept. Outputs return to reset values. A subsequent read of 0x30 returns 0x0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked word RAM with byte strobes, programmable latency and error responses
module dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d, wstrb_q, wstrb_d, a_wstrb;
   logic we_q, we_d, err_q, err_d, req_fire, acc, a_we, a_err;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, a_addr, a_wdata;
   logic [ADDR_WIDTH-1:0] a_idx;
   logic [31:0] mem [2**ADDR_WIDTH];
   always_comb begin
      req_fire = req_valid && state_q == IDLE;
      // zero latency performs the access on the accept edge, straight from the request
      a_we = (LATENCY == 0) ? req_we : we_q;
      a_addr = (LATENCY == 0) ? req_addr : addr_q;
      a_wdata = (LATENCY == 0) ? req_wdata : wdata_q;
      a_wstrb = (LATENCY == 0) ? req_wstrb : wstrb_q;
      acc = (LATENCY == 0) ? req_fire : (state_q == WAIT && cnt_q == 4'd0);
      a_err = a_addr[1:0] != 2'b00 || (a_addr >> (ADDR_WIDTH + 2)) != 32'd0;
      a_idx = a_addr[ADDR_WIDTH+1:2];
      state_d = state_q;
      cnt_d = cnt_q;
      we_d = req_fire ? req_we : we_q;
      addr_d = req_fire ? req_addr : addr_q;
      wdata_d = req_fire ? req_wdata : wdata_q;
      wstrb_d = req_fire ? req_wstrb : wstrb_q;
      rdata_d = acc ? ((a_we || a_err) ? 32'd0 : mem[a_idx]) : rdata_q;
      err_d = acc ? a_err : err_q;
      case (state_q)
         IDLE: if (req_fire) begin
            state_d = (LATENCY == 0) ? RESP : WAIT;
            cnt_d = 4'(LATENCY - 1);
         end
         WAIT: if (acc) state_d = RESP; else cnt_d = cnt_q - 4'd1;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= 4'd0;
         rdata_q <= 32'd0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
      end
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end
   always_ff @(posedge clk)
      if (!rst && acc && a_we && !a_err)
         for (int i = 0; i < 4; i++)
            if (a_wstrb[i]) mem[a_idx][8*i+:8] <= a_wdata[8*i+:8];
   assign req_ready = state_q == IDLE;
   assign rsp_valid = state_q == RESP;
   assign rsp_rdata = rdata_q;
   assign rsp_err = err_q;
endmodule
